// File: rtl/mmio_bridge_timer.sv
// MEM-stage bridge: routes CPU loads/stores to data memory or a countdown timer.
// The timer raises a registered interrupt when its count expires.
module mmio_bridge_timer #(
  parameter logic [31:0] DM_LIMIT   = 32'h0000_2FFF,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_byteen,
  input  logic [31:0] dm_rdata,
  output logic        timer_irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic hit_dm, hit_tm, wr_tm;
  logic wr_ctrl, wr_preset;

  assign hit_dm = (cpu_addr <= DM_LIMIT);
  assign hit_tm = (cpu_addr >= TIMER_BASE) &&
                  (cpu_addr <= TIMER_BASE + 32'd11);

  // Only full-word stores reach the timer registers.
  assign wr_tm     = hit_tm && (cpu_byteen == 4'b1111);
  assign wr_ctrl   = wr_tm && (cpu_addr[3:2] == 2'd0);
  assign wr_preset = wr_tm && (cpu_addr[3:2] == 2'd1);

  assign dm_addr   = cpu_addr;
  assign dm_wdata  = cpu_wdata;
  assign dm_byteen = hit_dm ? cpu_byteen : 4'b0000;
  assign timer_irq = irq_q & ctrl_q[3];

  always_comb begin
    cpu_rdata = 32'd0;
    unique case (1'b1)
      hit_dm: cpu_rdata = dm_rdata;
      hit_tm: begin
        case (cpu_addr[3:2])
          2'd0:    cpu_rdata = {28'd0, ctrl_q};
          2'd1:    cpu_rdata = preset_q;
          2'd2:    cpu_rdata = count_q;
          default: cpu_rdata = 32'd0;
        endcase
      end
      default: cpu_rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0]) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) begin
          state_d = IDLE;
        end else if (count_q == 32'd0) begin
          state_d = INT;
          irq_d   = 1'b1;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      INT: begin
        state_d = IDLE;
        if (ctrl_q[2:1] == 2'b01) irq_d = 1'b0;
        else ctrl_d[0] = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // A CPU store to CTRL overrides whatever the FSM did this cycle.
    if (wr_ctrl) begin
      ctrl_d = cpu_wdata[3:0];
      irq_d  = 1'b0;
    end
    if (wr_preset) preset_d = cpu_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'd0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

endmodule

// File: tb/tb_mmio_bridge_timer.sv
// Directed bench for mmio_bridge_timer with a queue of expected values.
// Expectations are pushed when stimulus is applied and popped at compare time.
module tb_mmio_bridge_timer;

  localparam logic [31:0] TB  = 32'h0000_7F00;
  localparam logic [31:0] CTL = TB;
  localparam logic [31:0] PRE = TB + 32'd4;
  localparam logic [31:0] CNA = TB + 32'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_byteen;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_byteen;
  logic        timer_irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] sbq[$];
  logic [31:0] d;

  mmio_bridge_timer dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_rdata  (cpu_rdata),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_byteen  (dm_byteen),
    .dm_rdata   (dm_rdata),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  function automatic void exp_v(input logic [31:0] v);
    sbq.push_back(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v,
                    input logic [3:0] be);
    cpu_addr   = a;
    cpu_wdata  = v;
    cpu_byteen = be;
    tick();
    cpu_byteen = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    cpu_addr   = a;
    cpu_byteen = 4'b0000;
    #1;
    v = cpu_rdata;
  endtask

  task automatic chk_irq(input string tag, input logic e);
    exp_v({31'd0, e});
    chk(tag, {31'd0, timer_irq});
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a,
                        input logic [31:0] e);
    logic [31:0] v;
    exp_v(e);
    rd(a, v);
    chk(tag, v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    cpu_addr   = 32'hFFFF_0000;
    cpu_wdata  = 32'd0;
    cpu_byteen = 4'b0000;
    dm_rdata   = 32'd0;
    tick();
    tick();
    chk_irq("rst_irq", 1'b0);
    chk_rd("rst_ctrl", CTL, 32'd0);
    chk_rd("rst_preset", PRE, 32'd0);
    chk_rd("rst_count", CNA, 32'd0);
    reset = 1'b0;
    tick();

    // Data-memory store and load
    cpu_addr = 32'h10; cpu_wdata = 32'hDEAD_BEEF; cpu_byteen = 4'hF;
    exp_v(32'hF);          exp_v(32'hDEAD_BEEF);  exp_v(32'h10);
    #1;
    chk("dm_be", {28'd0, dm_byteen});
    chk("dm_wdata", dm_wdata);
    chk("dm_addr", dm_addr);
    tick();
    cpu_byteen = 4'h0;
    dm_rdata = 32'h1234_5678;
    chk_rd("dm_load", 32'h10, 32'h1234_5678);
    cpu_addr = 32'h0000_2FFF; cpu_byteen = 4'hF;
    exp_v(32'hF);
    #1;
    chk("dm_limit_be", {28'd0, dm_byteen});
    cpu_addr = 32'h0000_3000;
    exp_v(32'h0);
    #1;
    chk("above_limit_be", {28'd0, dm_byteen});
    cpu_addr = 32'h0000_5000;
    exp_v(32'h0);
    #1;
    chk("unmapped_be", {28'd0, dm_byteen});
    tick();
    cpu_byteen = 4'h0;
    dm_rdata = 32'hA5A5_A5A5;
    chk_rd("unmapped_rd", 32'h0000_5000, 32'd0);
    chk_rd("tm_end_rd", TB + 32'd12, 32'd0);
    chk_rd("ctrl_after_dm", CTL, 32'd0);

    // One-shot: PRESET=5, CTRL=9
    cpu_addr = PRE; cpu_wdata = 32'd5; cpu_byteen = 4'hF;
    exp_v(32'h0);
    #1;
    chk("tm_wr_dm_be", {28'd0, dm_byteen});
    tick();
    cpu_byteen = 4'h0;
    chk_rd("preset5", PRE, 32'd5);
    wr(CTL, 32'h9, 4'hF);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_irq("os_irq", k >= 8);
      if (k >= 2) chk_rd("os_count", CNA, (k <= 7) ? 32'(7 - k) : 32'd0);
    end
    chk_rd("os_ctrl_after", CTL, 32'h8);
    wr(CTL, 32'h0, 4'b0011);
    chk_rd("partial_ctrl", CTL, 32'h8);
    chk_irq("partial_irq", 1'b1);
    wr(CNA, 32'h55, 4'hF);
    chk_rd("count_ro", CNA, 32'd0);
    wr(CTL, 32'h0, 4'hF);
    chk_irq("ctrl_wr_clears", 1'b0);

    // Auto-reload with PRESET=2
    wr(PRE, 32'd2, 4'hF);
    wr(CTL, 32'hB, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk_irq("ar_irq", (k == 5) || (k == 11));
    end
    chk_rd("ar_count", CNA, 32'd2);
    wr(CTL, 32'h0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_irq("stop_irq", 1'b0);
      chk_rd("stop_count", CNA, 32'd1);
    end

    // PRESET=0, then CTRL write while in INT
    wr(PRE, 32'd0, 4'hF);
    wr(CTL, 32'h9, 4'hF);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_irq("p0_irq", k == 3);
    end
    wr(CTL, 32'hB, 4'hF);
    chk_rd("int_ctrl_wins", CTL, 32'hB);
    chk_irq("int_irq_clr", 1'b0);
    wr(CTL, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) tick();

    // PRESET change during CNT applies only at next LOAD
    wr(PRE, 32'd4, 4'hF);
    wr(CTL, 32'h9, 4'hF);
    tick(); tick(); tick();
    wr(PRE, 32'd1, 4'hF);
    for (int k = 5; k <= 7; k++) begin
      tick();
      chk_irq("mid_pre_irq", k == 7);
      if (k == 5) chk_rd("mid_pre_count", CNA, 32'd1);
    end
    tick(); tick();
    wr(CTL, 32'h9, 4'hF);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk_irq("new_pre_irq", k == 4);
      if (k == 2) chk_rd("new_pre_count", CNA, 32'd1);
    end
    wr(CTL, 32'h0, 4'hF);
    tick(); tick();

    // Reset in the middle of a count
    wr(PRE, 32'd10, 4'hF);
    wr(CTL, 32'h9, 4'hF);
    for (int k = 1; k <= 9; k++) tick();
    chk_rd("pre_rst_count", CNA, 32'd3);
    reset = 1'b1;
    #1;
    chk_rd("mid_rst_ctrl", CTL, 32'd0);
    chk_rd("mid_rst_count", CNA, 32'd0);
    chk_irq("mid_rst_irq", 1'b0);
    tick();
    reset = 1'b0;
    wr(PRE, 32'd7, 4'hF);
    chk_rd("post_rst_pre", PRE, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_rd("post_rst_count", CNA, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmio_bridge_timer.md
Name: mmio_bridge_timer

Overview:
- Sits directly downstream of the pipelined CPU's MEM-stage data port and consumes its address, write data and byte-enable outputs.
- Decodes each access to one of two targets: the external data memory or an on-block programmable countdown timer.
- Returns the selected read data to the CPU.
- Drives a timer interrupt line for the later exception/interrupt stage.

Parameters:
- DM_LIMIT, 32'h0000_2FFF, highest byte address routed to data memory; data memory starts at 0.
- TIMER_BASE, 32'h0000_7F00, base of the 12-byte timer register window.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_addr  in  32  MEM-stage byte address
- cpu_wdata  in  32  MEM-stage store data
- cpu_byteen  in  4  MEM-stage byte enables; 4'b0000 means no write
- cpu_rdata  out  32  read data returned to the CPU (combinational)
- dm_addr  out  32  address to data memory (copy of cpu_addr)
- dm_wdata  out  32  store data to data memory (copy of cpu_wdata)
- dm_byteen  out  4  cpu_byteen when the access hits data memory, else 4'b0000
- dm_rdata  in  32  data-memory read data
- timer_irq  out  1  timer interrupt, registered

Behaviour:
- Address decode, combinational:
  - hit_dm when cpu_addr <= DM_LIMIT.
  - hit_tm when TIMER_BASE <= cpu_addr <= TIMER_BASE+11.
  - Any other address: writes are dropped and cpu_rdata = 0.
- Read mux:
  - hit_dm: cpu_rdata = dm_rdata.
  - hit_tm: cpu_rdata = the addressed timer register, selected by cpu_addr[3:2].
- Timer registers:
  - CTRL, offset 0: bit0 EN, bits[2:1] MODE, bit3 IM. Bits 31:4 read as 0.
  - PRESET, offset 4: 32 bits.
  - COUNT, offset 8: read-only.
- Timer write rules:
  - Writes take effect only when hit_tm and cpu_byteen == 4'b1111.
  - Partial-byte timer writes are ignored.
  - Writes to COUNT are ignored.
- Reset (asynchronous): CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. timer_irq is therefore 0.
- FSM states: IDLE, LOAD, CNT, INT. Transitions evaluated at each posedge:
  - IDLE: if EN=1, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, checked in this order:
    - EN=0: go to IDLE, COUNT holds its value.
    - COUNT==0: go to INT, irq_flag <= 1.
    - Otherwise COUNT <= COUNT-1.
  - INT:
    - MODE==2'b00 (one-shot): EN <= 0, go to IDLE. irq_flag stays set until the next CTRL write.
    - MODE==2'b01 (auto-reload): irq_flag <= 0, go to IDLE. EN stays 1, so the timer reloads through LOAD.
    - MODE 2'b10/2'b11: treated as 2'b00.
- timer_irq = irq_flag & CTRL.IM.
- Latency: after the edge that writes EN=1, irq_flag rises on edge PRESET+3.
  - Auto-reload period: PRESET+4 cycles.
- Boundaries:
  - PRESET=0: LOAD then CNT then INT; irq_flag set on edge 3 after the EN write.
  - PRESET write during CNT: no effect on the running count; used at the next LOAD.
  - CTRL write in the same cycle the FSM is in INT: the CPU write wins for every CTRL bit; irq_flag is cleared.
  - Any CTRL write clears irq_flag.
  - COUNT is 32-bit unsigned; PRESET=32'hFFFF_FFFF counts fully without wrap.
  - Reset asserted mid-count returns the block immediately to the reset values.
- Data memory is never written on a timer access, and the timer is never written on a data-memory access.

Test Plan:
- Store word 32'hDEAD_BEEF to 0x0000_0010 with byteen 4'b1111 -> dm_byteen=4'b1111, dm_wdata=32'hDEAD_BEEF. Drive dm_rdata=32'h1234_5678 on a load from 0x10 -> cpu_rdata=32'h1234_5678.
- Write PRESET=5, then CTRL=32'h9 (EN, IM, one-shot) -> COUNT reads 5,4,3,2,1,0. timer_irq rises on the 8th edge after the CTRL write and stays high. CTRL then reads 32'h8.
- Write CTRL=32'hB (auto-reload, IM) with PRESET=2 -> timer_irq pulses high for 1 cycle every 6 cycles. A subsequent write of CTRL=0 stops the pulses and leaves COUNT frozen.
- Write CTRL with byteen 4'b0011 -> CTRL unchanged. Store to 0x0000_5000 -> dm_byteen=0 and a read returns 0.
- Write PRESET=0 and EN=1 -> irq_flag is set on edge 3 after the write.
- Assert reset mid-count (COUNT=3) -> CTRL, COUNT and timer_irq are 0 immediately; after release the FSM stays in IDLE.
